lcd_refresh_scheduler: RTL and testbench
========================================

# lcd_refresh_scheduler

Schedules and rate-limits refreshes of the LCD1602 text controller in the feeder display path. Two requesters share the display: the timekeeping source (per-second tick) and the dispenser event source (a portion was served). The block merges and prioritises their requests, snapshots all display fields at grant time, pulses a start to the LCD controller, and waits on its busy handshake. It also enforces a minimum gap between refreshes.

## Interface
Parameters:
- `MIN_GAP_CYCLES`, 800_000: idle cycles enforced after each tick-sourced refresh (16 ms at 50 MHz).
- `TIMEOUT_CYCLES`, 5_000_000: watchdog limit per handshake phase. Used only when the watchdog is compiled in.
- `DATA_BITS`, 8: width of each display field.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `tick_i`  in  1: one-cycle pulse requesting a time refresh.
- `hours_i`, `minutes_i`, `seconds_i`  in  DATA_BITS each: live time fields.
- `feed_evt_i`  in  1: one-cycle pulse requesting an event refresh.
- `porciones_i`  in  DATA_BITS: live portion count.
- `lcd_busy_i`  in  1: LCD controller is writing; high from acceptance to completion.
- `lcd_start_o`  out  1: one-cycle refresh start pulse.
- `time_hours_o`, `time_minutes_o`, `time_seconds_o`, `porciones_o`  out  DATA_BITS each: registered snapshot. Held stable from grant to the next grant.
- `src_o`  out  1: source of the last grant (1 = event, 0 = tick).
- `drop_cnt_o`  out  8: saturating count of coalesced tick requests.
- `timeout_o`  out  1: sticky watchdog flag.

## Operation
- Pending flags `pend_tick` and `pend_evt` are each set by their pulse and cleared at grant.
- If a set and a clear occur in the same cycle, the set wins and the request stays pending.
- `tick_i` arriving while `pend_tick` is already set increments `drop_cnt_o`, saturating at 255. Events never count as drops.
- FSM states are IDLE, GRANT, WAIT_ACK, WAIT_DONE and GAP.
  - IDLE: if either flag is set, go to GRANT.
  - GRANT (one cycle): load all four snapshot registers from the live inputs at that cycle, not at request time. Assert `lcd_start_o`. Set `src_o` = `pend_evt`. Clear both flags, because one refresh serves both requesters. Go to WAIT_ACK.
  - WAIT_ACK: go to WAIT_DONE when `lcd_busy_i` = 1.
  - WAIT_DONE: go to GAP when `lcd_busy_i` = 0.
  - GAP: count from 0 and go to IDLE after `MIN_GAP_CYCLES` cycles. If `pend_evt` is set, go directly to GRANT (events bypass the gap). Ticks always wait out the gap.
- Priority: when both flags are set at grant, the event wins (`src_o` = 1).
- Reset mid-operation: the FSM returns to IDLE and flags, counters and all outputs return to reset values immediately. Any LCD write in flight is abandoned without a start.

Reset values:
- `lcd_start_o` = 0
- all snapshot outputs = 0
- `src_o` = 0
- `drop_cnt_o` = 0
- `timeout_o` = 0

## Timing
- A request pulse sampled at edge k sets its flag at edge k.
- From IDLE, `lcd_start_o` is high for exactly the cycle after edge k+1. Request-to-start latency is 2 cycles.
- Snapshot outputs change at the same edge that raises `lcd_start_o`.
- `lcd_busy_i` may rise in the cycle immediately after start.
- Minimum tick-to-tick refresh period is 2 + ack latency + busy duration + `MIN_GAP_CYCLES` + 1.
- `lcd_start_o` is never asserted outside GRANT. No back-to-back starts are possible.

## Configuration
- `LCD_REFRESH_WATCHDOG_EN` defined:
  - A counter runs in WAIT_ACK and WAIT_DONE and restarts on each state entry.
  - When it reaches `TIMEOUT_CYCLES`, set `timeout_o` (sticky until reset) and go to GAP.
- `LCD_REFRESH_WATCHDOG_EN` undefined:
  - No counter is built and `timeout_o` is tied 0.
  - The FSM waits indefinitely on `lcd_busy_i`.

## Test plan
All scenarios use `MIN_GAP_CYCLES` = 50 and `TIMEOUT_CYCLES` = 200. A busy-model responder raises busy 1 cycle after start and holds it 20 cycles.
- Tick with hours/minutes/seconds = 10/0/5 and porciones = 6 → `lcd_start_o` pulse 2 cycles later; snapshot = 10/0/5/6; `src_o` = 0.
- `tick_i` and `feed_evt_i` in the same cycle → a single start with `src_o` = 1, and no second refresh follows.
- Three ticks during WAIT_DONE → exactly one further refresh after the gap; `drop_cnt_o` = 2.
- Tick refresh done, then `feed_evt_i` 5 cycles into GAP → start 1–2 cycles later, without waiting out the 50-cycle gap.
- Responder never raises busy → with the macro, `timeout_o` = 1 at 200 cycles and the FSM recovers to IDLE; without the macro, the FSM stays in WAIT_ACK.
- `reset` asserted during WAIT_DONE → all outputs 0 asynchronously; a tick after release yields a normal start.

Source files
------------

// File: rtl/lcd_refresh_scheduler.sv
// lcd_refresh_scheduler
// Merges the per-second tick and the dispenser event refresh requests for the
// LCD1602 controller. It snapshots all display fields at grant, pulses a start,
// follows the busy handshake and then enforces a minimum gap. Events may cut
// the gap short; ticks never do.
// Optional handshake watchdog: define LCD_REFRESH_WATCHDOG_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | nothing in flight, waiting for a pending request
// GRANT     | snapshot loaded, start pulse high, pending flags cleared
// WAIT_ACK  | waiting for the controller to raise busy
// WAIT_DONE | controller writing, waiting for busy to fall
// GAP       | rate-limit gap after a refresh; a pending event jumps to GRANT
module lcd_refresh_scheduler #(
    parameter int MIN_GAP_CYCLES = 800_000,
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int DATA_BITS      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_i,
    input  logic [DATA_BITS-1:0] hours_i,
    input  logic [DATA_BITS-1:0] minutes_i,
    input  logic [DATA_BITS-1:0] seconds_i,
    input  logic                 feed_evt_i,
    input  logic [DATA_BITS-1:0] porciones_i,
    input  logic                 lcd_busy_i,
    output logic                 lcd_start_o,
    output logic [DATA_BITS-1:0] time_hours_o,
    output logic [DATA_BITS-1:0] time_minutes_o,
    output logic [DATA_BITS-1:0] time_seconds_o,
    output logic [DATA_BITS-1:0] porciones_o,
    output logic                 src_o,
    output logic [7:0]           drop_cnt_o,
    output logic                 timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    // Gap timer is a down-counter loaded on GAP entry; GAP lasts MIN_GAP_CYCLES cycles.
    localparam int GAP_W = (MIN_GAP_CYCLES > 1) ? $clog2(MIN_GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP_CYCLES - 1);

    state_t               state_q, state_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                 pend_tick_q, pend_tick_d;
    logic                 pend_evt_q, pend_evt_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;
    logic                 start_q, start_d;
    logic                 src_q, src_d;
    logic [DATA_BITS-1:0] hours_q, hours_d;
    logic [DATA_BITS-1:0] minutes_q, minutes_d;
    logic [DATA_BITS-1:0] seconds_q, seconds_d;
    logic [DATA_BITS-1:0] porciones_q, porciones_d;

    logic grant;
    logic clr_flags;
    logic wd_fire;

    // Snapshot, start and src are all loaded on the edge that enters GRANT,
    // so the start pulse and the new snapshot appear together.
    assign grant     = (state_d == S_GRANT);
    assign clr_flags = (state_q == S_GRANT);

`ifdef LCD_REFRESH_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;
    logic            stalled;

    // Only a handshake that is still waiting can time out.
    assign stalled = ((state_q == S_WAIT_ACK) && !lcd_busy_i) ||
                     ((state_q == S_WAIT_DONE) && lcd_busy_i);
    assign wd_fire = stalled && (wd_cnt_q == '0);

    // Watchdog down-counter, reloaded on every entry to a handshake state.
    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q | wd_fire;
        if ((state_d != state_q) && ((state_d == S_WAIT_ACK) || (state_d == S_WAIT_DONE))) begin
            wd_cnt_d = WD_LOAD;
        end else if (((state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE)) && (wd_cnt_q != '0)) begin
            wd_cnt_d = wd_cnt_q - 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    // Keeps the timeout parameter referenced in builds without the watchdog.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Next-state logic and gap timer.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pend_tick_q || pend_evt_q) state_d = S_GRANT;
            end
            S_GRANT: begin
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (lcd_busy_i)   state_d = S_WAIT_DONE;
                else if (wd_fire) state_d = S_GAP;
            end
            S_WAIT_DONE: begin
                if (!lcd_busy_i || wd_fire) state_d = S_GAP;
            end
            S_GAP: begin
                if (pend_evt_q)             state_d = S_GRANT;
                else if (gap_cnt_q == '0)   state_d = S_IDLE;
                else                        gap_cnt_d = gap_cnt_q - 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if ((state_d == S_GAP) && (state_q != S_GAP)) gap_cnt_d = GAP_LOAD;
    end

    // Request flags, drop counter and grant-time snapshot.
    always_comb begin
        pend_tick_d = tick_i | (pend_tick_q & ~clr_flags);
        pend_evt_d  = feed_evt_i | (pend_evt_q & ~clr_flags);
        drop_cnt_d  = drop_cnt_q;
        // A tick landing on the grant cycle stays pending, so it is not a drop.
        if (tick_i && pend_tick_q && !clr_flags && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
        start_d     = grant;
        src_d       = src_q;
        hours_d     = hours_q;
        minutes_d   = minutes_q;
        seconds_d   = seconds_q;
        porciones_d = porciones_q;
        if (grant) begin
            src_d       = pend_evt_q;
            hours_d     = hours_i;
            minutes_d   = minutes_i;
            seconds_d   = seconds_i;
            porciones_d = porciones_i;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gap_cnt_q   <= '0;
            pend_tick_q <= 1'b0;
            pend_evt_q  <= 1'b0;
            drop_cnt_q  <= 8'd0;
            start_q     <= 1'b0;
            src_q       <= 1'b0;
            hours_q     <= '0;
            minutes_q   <= '0;
            seconds_q   <= '0;
            porciones_q <= '0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            pend_tick_q <= pend_tick_d;
            pend_evt_q  <= pend_evt_d;
            drop_cnt_q  <= drop_cnt_d;
            start_q     <= start_d;
            src_q       <= src_d;
            hours_q     <= hours_d;
            minutes_q   <= minutes_d;
            seconds_q   <= seconds_d;
            porciones_q <= porciones_d;
        end
    end

    assign lcd_start_o    = start_q;
    assign src_o          = src_q;
    assign drop_cnt_o     = drop_cnt_q;
    assign time_hours_o   = hours_q;
    assign time_minutes_o = minutes_q;
    assign time_seconds_o = seconds_q;
    assign porciones_o    = porciones_q;

endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// Directed bench for lcd_refresh_scheduler with MIN_GAP_CYCLES=50,
// TIMEOUT_CYCLES=200 and a busy responder (busy one cycle after start, 20 cycles).
module tb_lcd_refresh_scheduler;

    logic       clk;
    logic       reset;
    logic       tick_i;
    logic       feed_evt_i;
    logic       lcd_busy_i;
    logic [7:0] hours_i, minutes_i, seconds_i, porciones_i;
    logic       lcd_start_o;
    logic [7:0] time_hours_o, time_minutes_o, time_seconds_o, porciones_o;
    logic       src_o;
    logic [7:0] drop_cnt_o;
    logic       timeout_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_starts = 0;
    int   last_start_cyc = 0;
    logic resp_en = 1'b1;
    logic start_dly = 1'b0;
    int   busy_left = 0;

    lcd_refresh_scheduler #(
        .MIN_GAP_CYCLES(50),
        .TIMEOUT_CYCLES(200),
        .DATA_BITS(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick_i(tick_i),
        .hours_i(hours_i),
        .minutes_i(minutes_i),
        .seconds_i(seconds_i),
        .feed_evt_i(feed_evt_i),
        .porciones_i(porciones_i),
        .lcd_busy_i(lcd_busy_i),
        .lcd_start_o(lcd_start_o),
        .time_hours_o(time_hours_o),
        .time_minutes_o(time_minutes_o),
        .time_seconds_o(time_seconds_o),
        .porciones_o(porciones_o),
        .src_o(src_o),
        .drop_cnt_o(drop_cnt_o),
        .timeout_o(timeout_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Busy responder: busy rises one cycle after the start cycle, holds 20 cycles.
    initial begin
        lcd_busy_i = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_left > 0) busy_left--;
            if (start_dly && resp_en) busy_left = 20;
            start_dly  = lcd_start_o;
            lcd_busy_i = (busy_left > 0);
        end
    end

    // Start monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (lcd_start_o === 1'b1) begin
                n_starts++;
                last_start_cyc = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish before 500000");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic t, input logic e);
        tick_i     = t;
        feed_evt_i = e;
        @(negedge clk);
        tick_i     = 1'b0;
        feed_evt_i = 1'b0;
    endtask

    task automatic wait_start(input int max, output int n);
        n = 0;
        while ((n < max) && (lcd_start_o !== 1'b1)) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"},   lcd_start_o,    0);
        check({tag, "_hours"},   time_hours_o,   0);
        check({tag, "_minutes"}, time_minutes_o, 0);
        check({tag, "_seconds"}, time_seconds_o, 0);
        check({tag, "_porc"},    porciones_o,    0);
        check({tag, "_src"},     src_o,          0);
        check({tag, "_drop"},    drop_cnt_o,     0);
        check({tag, "_timeout"}, timeout_o,      0);
    endtask

    initial begin
        int lat;
        int base_n;
        int base_cyc;

        reset = 1'b1;
        tick_i = 1'b0;
        feed_evt_i = 1'b0;
        hours_i = 8'd0; minutes_i = 8'd0; seconds_i = 8'd0; porciones_i = 8'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_start", lcd_start_o, 0);

        // Plain tick refresh, 10/0/5/6.
        hours_i = 8'd10; minutes_i = 8'd0; seconds_i = 8'd5; porciones_i = 8'd6;
        pulse(1'b1, 1'b0);
        check("s1_no_early_start", lcd_start_o, 0);
        wait_start(10, lat);
        check("s1_latency", lat + 1, 2);
        check("s1_hours", time_hours_o, 10);
        check("s1_minutes", time_minutes_o, 0);
        check("s1_seconds", time_seconds_o, 5);
        check("s1_porc", porciones_o, 6);
        check("s1_src", src_o, 0);
        hours_i = 8'd11; porciones_i = 8'd9;
        @(negedge clk);
        check("s1_start_one_cycle", lcd_start_o, 0);
        repeat (5) @(negedge clk);
        check("s1_hold_hours", time_hours_o, 10);
        check("s1_hold_porc", porciones_o, 6);
        repeat (100) @(negedge clk);

        // Tick and event together: one refresh, event wins.
        hours_i = 8'd1; minutes_i = 8'd2; seconds_i = 8'd3; porciones_i = 8'd4;
        pulse(1'b1, 1'b1);
        wait_start(10, lat);
        check("s2_latency", lat + 1, 2);
        check("s2_src", src_o, 1);
        check("s2_hours", time_hours_o, 1);
        check("s2_porc", porciones_o, 4);
        @(negedge clk);
        base_n = n_starts;
        repeat (150) @(negedge clk);
        check("s2_no_second_refresh", n_starts - base_n, 0);
        check("s2_drop", drop_cnt_o, 0);

        // Three ticks during WAIT_DONE: one more refresh after the gap, two drops.
        pulse(1'b1, 1'b0);
        wait_start(10, lat);
        check("s3_latency", lat + 1, 2);
        @(negedge clk);
        base_n   = n_starts;
        base_cyc = last_start_cyc;
        repeat (3) @(negedge clk);
        pulse(1'b1, 1'b0);
        @(negedge clk);
        pulse(1'b1, 1'b0);
        @(negedge clk);
        pulse(1'b1, 1'b0);
        check("s3_drop", drop_cnt_o, 2);
        repeat (100) @(negedge clk);
        check("s3_one_more_refresh", n_starts - base_n, 1);
        check("s3_start_to_start", last_start_cyc - base_cyc, 73);
        check("s3_src", src_o, 0);
        repeat (60) @(negedge clk);

        // Event five cycles into GAP bypasses the gap.
        hours_i = 8'd23; minutes_i = 8'd59; seconds_i = 8'd58; porciones_i = 8'd1;
        pulse(1'b1, 1'b0);
        wait_start(10, lat);
        check("s4_tick_latency", lat + 1, 2);
        check("s4_tick_hours", time_hours_o, 23);
        repeat (27) @(negedge clk);
        hours_i = 8'd7; minutes_i = 8'd8; seconds_i = 8'd9; porciones_i = 8'd2;
        pulse(1'b0, 1'b1);
        check("s4_no_early_start", lcd_start_o, 0);
        wait_start(10, lat);
        check("s4_evt_bypass_latency", lat + 1, 2);
        check("s4_src", src_o, 1);
        check("s4_hours", time_hours_o, 7);
        check("s4_seconds", time_seconds_o, 9);
        check("s4_porc", porciones_o, 2);
        repeat (150) @(negedge clk);

        // Reset in WAIT_DONE clears everything at once; normal start afterwards.
        hours_i = 8'd3; minutes_i = 8'd4; seconds_i = 8'd5; porciones_i = 8'd99;
        pulse(1'b0, 1'b1);
        wait_start(10, lat);
        check("s6_latency", lat + 1, 2);
        repeat (5) @(negedge clk);
        check("s6_pre_drop", drop_cnt_o, 2);
        check("s6_pre_src", src_o, 1);
        check("s6_pre_porc", porciones_o, 99);
        reset = 1'b1;
        #1;
        check_all_zero("s6_async_reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("s6_idle_after_release", lcd_start_o, 0);
        hours_i = 8'd12; minutes_i = 8'd34; seconds_i = 8'd56; porciones_i = 8'd78;
        pulse(1'b1, 1'b0);
        wait_start(10, lat);
        check("s6_post_latency", lat + 1, 2);
        check("s6_post_hours", time_hours_o, 12);
        check("s6_post_minutes", time_minutes_o, 34);
        check("s6_post_porc", porciones_o, 78);
        check("s6_post_src", src_o, 0);
        check("s6_post_drop", drop_cnt_o, 0);
        repeat (100) @(negedge clk);

        // Responder never raises busy.
        resp_en = 1'b0;
        pulse(1'b1, 1'b0);
        wait_start(10, lat);
        check("s5_latency", lat + 1, 2);
`ifdef LCD_REFRESH_WATCHDOG_EN
        repeat (195) @(negedge clk);
        check("s5_timeout_not_yet", timeout_o, 0);
        repeat (10) @(negedge clk);
        check("s5_timeout_set", timeout_o, 1);
        repeat (60) @(negedge clk);
        pulse(1'b1, 1'b0);
        wait_start(10, lat);
        check("s5_recover_latency", lat + 1, 2);
        check("s5_timeout_sticky", timeout_o, 1);
`else
        repeat (250) @(negedge clk);
        check("s5_timeout_tied", timeout_o, 0);
        pulse(1'b0, 1'b1);
        wait_start(60, lat);
        check("s5_stuck_no_start", lcd_start_o, 0);
        check("s5_src_held", src_o, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
